// File: rtl/dendrite_pkg.sv
// ---------------------------------------------------------------------------
// dendrite_pkg
// Shared types and helpers for the dendrite accumulator:
//   syn_event_t  - one buffered synaptic event (sign flag + unsigned weight)
//   state_t      - integration FSM states (ACCUM, EMIT)
//   sat_step     - saturating add / clamp-at-zero subtract on a wide operand
// The event weight width is fixed here because the packed event type is
// shared by the FIFO and the top; dendrite_accumulator's WEIGHT_WIDTH must
// equal SYN_WEIGHT_WIDTH.
// ---------------------------------------------------------------------------
package dendrite_pkg;

    localparam int SYN_WEIGHT_WIDTH = 6;

    // Working width of sat_step; covers accumulators up to 32 bits plus a
    // carry bit.
    localparam int SAT_W = 33;

    typedef struct packed {
        logic                        inhibitory;
        logic [SYN_WEIGHT_WIDTH-1:0] weight;
    } syn_event_t;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    // Excitatory: acc + term, clipped to max_val.
    // Inhibitory: acc - term, clipped to zero.
    function automatic logic [SAT_W-1:0] sat_step(
        input logic [SAT_W-1:0] acc,
        input logic [SAT_W-1:0] term,
        input logic             inhibitory,
        input logic [SAT_W-1:0] max_val
    );
        logic [SAT_W:0] sum;
        if (inhibitory) begin
            return (term >= acc) ? '0 : (acc - term);
        end
        sum = {1'b0, acc} + {1'b0, term};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/syn_event_fifo.sv
// ---------------------------------------------------------------------------
// syn_event_fifo
// Small register FIFO holding syn_event_t entries. An entry written on one
// clock edge is visible at pop_data and poppable from the next edge. Push and
// pop may occur in the same cycle at any occupancy; push is ignored when
// full and pop is ignored when empty.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset (empties FIFO)
//   push, push_data - write request and payload
//   pop             - read request; pop_data shows the head entry
//   full, empty     - occupancy flags derived from the registered count
// ---------------------------------------------------------------------------
module syn_event_fifo
    import dendrite_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  syn_event_t push_data,
    input  logic       pop,
    output syn_event_t pop_data,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    syn_event_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointers wrap naturally.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers/count define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/dendrite_accumulator.sv
// ---------------------------------------------------------------------------
// dendrite_accumulator
// Buffers weighted synaptic events and integrates them into a saturating
// synaptic current over a fixed window of WINDOW_CYCLES unfrozen ACCUM
// cycles, then presents the result to the neuron for one EMIT cycle.
// Optional build macro: DENDRITE_DECAY_EN - when defined, the accumulator
// restarts each window from 3/4 of the emitted value instead of zero.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   syn_valid/syn_ready - event handshake (ready = FIFO not full)
//   syn_weight          - unsigned event weight
//   syn_inhibitory      - 1 subtracts the weighted term, 0 adds it
//   freeze              - halts popping and the window counter in ACCUM
//   input_spike_valid   - one-cycle pulse when a nonzero current is emitted
//   input_current       - emitted current; zero whenever valid is low
// ---------------------------------------------------------------------------
module dendrite_accumulator
    import dendrite_pkg::*;
#(
    parameter int WEIGHT_WIDTH  = SYN_WEIGHT_WIDTH,
    parameter int CURRENT_WIDTH = 16,
    parameter int WEIGHT_SHIFT  = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int WINDOW_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     syn_valid,
    output logic                     syn_ready,
    input  logic [WEIGHT_WIDTH-1:0]  syn_weight,
    input  logic                     syn_inhibitory,
    input  logic                     freeze,
    output logic                     input_spike_valid,
    output logic [CURRENT_WIDTH-1:0] input_current
);

    localparam int CNT_W = $clog2(WINDOW_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [SAT_W-1:0] SAT_MAX  = SAT_W'({CURRENT_WIDTH{1'b1}});

    state_t                   state_q, state_d;
    logic [CURRENT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     valid_q, valid_d;
    logic [CURRENT_WIDTH-1:0] current_q, current_d;
    logic                     ready_en_q;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;
    logic                     fifo_push;
    syn_event_t               push_event;
    syn_event_t               head_event;
    logic [CURRENT_WIDTH:0]   term;
    logic [CURRENT_WIDTH-1:0] sat_res;

    // ready_en_q keeps syn_ready low while reset is asserted; after release
    // ready follows the registered full flag only.
    assign syn_ready  = ready_en_q && !fifo_full;
    assign fifo_push  = syn_valid && syn_ready;
    assign push_event = '{inhibitory: syn_inhibitory, weight: syn_weight};

    syn_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_event),
        .pop       (fifo_pop),
        .pop_data  (head_event),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Weighted term at CURRENT_WIDTH+1 bits so the sum can overflow before
    // saturation catches it.
    assign term = {{(CURRENT_WIDTH + 1 - WEIGHT_WIDTH){1'b0}}, head_event.weight}
                  << WEIGHT_SHIFT;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        current_d = current_q;
        fifo_pop  = 1'b0;
        sat_res   = acc_q;
        case (state_q)
            ACCUM: begin
                if (!freeze) begin
                    fifo_pop = !fifo_empty;
                    if (fifo_pop) begin
                        sat_res = CURRENT_WIDTH'(sat_step(SAT_W'(acc_q), SAT_W'(term),
                                                          head_event.inhibitory, SAT_MAX));
                    end
                    acc_d = sat_res;
                    if (cnt_q == CNT_LAST) begin
                        // Last ACCUM edge: the pop on this edge is included.
                        current_d = sat_res;
                        valid_d   = (sat_res != '0);
`ifdef DENDRITE_DECAY_EN
                        acc_d     = sat_res - (sat_res >> 2);
`else
                        acc_d     = '0;
`endif
                        cnt_d     = '0;
                        state_d   = EMIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                // Single cycle regardless of freeze.
                valid_d   = 1'b0;
                current_d = '0;
                state_d   = ACCUM;
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            current_q  <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            current_q  <= current_d;
            ready_en_q <= 1'b1;
        end
    end

    assign input_spike_valid = valid_q;
    assign input_current     = current_q;

endmodule
